// File: rtl/clock_ratio_monitor_if.sv
// Observation bundle between the slow-clock source side and the ratio monitor.
// Latency: none; it only groups wires.
// Backpressure: none; every output is a level or a strobe.
interface clock_ratio_monitor_if #(
    parameter int CNT_W = 8
) ();
    logic             clk_div_i;
    logic             enable_i;
    logic             clear_i;
    logic             edge_stb_o;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             locked_o;
    logic             fault_o;

    // Side that owns the slow clock and the control inputs.
    modport master (
        output clk_div_i, enable_i, clear_i,
        input  edge_stb_o, period_o, high_o, locked_o, fault_o
    );

    // The monitor itself.
    modport slave (
        input  clk_div_i, enable_i, clear_i,
        output edge_stb_o, period_o, high_o, locked_o, fault_o
    );
endinterface

// File: rtl/clock_ratio_monitor.sv
// Measures a divided clock in fast-clock cycles, strobes on its rising edges and declares ratio lock.
// Latency: clk_div_i high at fast edge N gives edge_stb_o and a new period_o after edge N+2; lock/fault react one cycle later.
// Backpressure: none; the strobe is free-running and the consumer must take it when it appears.
module clock_ratio_monitor #(
    parameter int DIVIDE_BY  = 4,
    parameter int TOLERANCE  = 0,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic                 clk_200M_i,
    input  logic                 rst_i,
    clock_ratio_monitor_if.slave mon
);
    // Acceptance window; the lower bound clamps at zero rather than wrapping.
    localparam int LO_I = (DIVIDE_BY > TOLERANCE) ? (DIVIDE_BY - TOLERANCE) : 0;
    localparam int HI_I = DIVIDE_BY + TOLERANCE;
    localparam logic [CNT_W-1:0] LO_B = LO_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] HI_B = HI_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    // Good-period counter only needs to reach LOCK_COUNT-1 before the lock transition.
    localparam int GW  = $clog2(LOCK_COUNT + 1);
    localparam int LM1 = LOCK_COUNT - 1;
    localparam logic [GW-1:0] LOCK_M1 = LM1[GW-1:0];

    typedef enum logic [1:0] {IDLE, ARM, TRACK, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [GW-1:0]    good_cnt, good_cnt_nxt;
    logic             s1, s2, s3;
    logic             rise, fall;
    logic [CNT_W-1:0] pc, hc;
    logic             meas_vld;
    logic             measuring;
    logic             pc_sat;
    logic             good;
    logic             fault_set;

    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign pc_sat    = (pc == '1);
    assign measuring = mon.enable_i && ((state == TRACK) || (state == LOCKED));
    // Judged one cycle after the rise, on the value that was just captured.
    assign good      = (mon.period_o >= LO_B) && (mon.period_o <= HI_B);
    assign mon.locked_o = (state == LOCKED);

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk_200M_i) begin
        if (rst_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mon.clk_div_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Period/high counters and captured measurements; counters are flushed whenever the monitor is idle.
    always_ff @(posedge clk_200M_i) begin
        if (rst_i) begin
            pc             <= '0;
            hc             <= '0;
            mon.period_o   <= '0;
            mon.high_o     <= '0;
            mon.edge_stb_o <= 1'b0;
            meas_vld       <= 1'b0;
        end else begin
            mon.edge_stb_o <= rise && mon.enable_i && (state != IDLE);
            meas_vld       <= rise && measuring;
            if (!mon.enable_i || (state == IDLE)) begin
                pc <= '0;
                hc <= '0;
            end else begin
                if (rise) begin
                    pc <= ONE;
                    if (measuring) mon.period_o <= pc;
                end else if (!pc_sat) begin
                    pc <= pc + ONE;
                end
                if (rise) begin
                    hc <= ONE;
                end else if (s2 && (hc != '1)) begin
                    hc <= hc + ONE;
                end
                if (fall && measuring) mon.high_o <= hc;
            end
        end
    end

    // State, good-period count and sticky fault; a fault set wins over a simultaneous clear.
    always_ff @(posedge clk_200M_i) begin
        if (rst_i) begin
            state       <= IDLE;
            good_cnt    <= '0;
            mon.fault_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
            if (fault_set) begin
                mon.fault_o <= 1'b1;
            end else if (mon.clear_i) begin
                mon.fault_o <= 1'b0;
            end
        end
    end

    // Next state: enable low dominates, then timeout, then the verdict on the captured period.
    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        fault_set    = 1'b0;
        if (!mon.enable_i) begin
            state_nxt    = IDLE;
            good_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt    = ARM;
                    good_cnt_nxt = '0;
                end
                ARM: begin
                    if (rise) begin
                        state_nxt    = TRACK;
                        good_cnt_nxt = '0;
                    end
                end
                TRACK: begin
                    if (pc_sat) begin
                        state_nxt    = ARM;
                        good_cnt_nxt = '0;
                    end else if (meas_vld) begin
                        if (!good) begin
                            good_cnt_nxt = '0;
                        end else if (good_cnt == LOCK_M1) begin
                            state_nxt    = LOCKED;
                            good_cnt_nxt = '0;
                        end else begin
                            good_cnt_nxt = good_cnt + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (pc_sat) begin
                        state_nxt    = ARM;
                        good_cnt_nxt = '0;
                        fault_set    = 1'b1;
                    end else if (meas_vld && !good) begin
                        state_nxt    = TRACK;
                        good_cnt_nxt = '0;
                        fault_set    = 1'b1;
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    good_cnt_nxt = '0;
                end
            endcase
        end
    end
endmodule

// File: doc/clock_ratio_monitor.md
# clock_ratio_monitor

Fast-domain consumer of the divided clock. It samples the slow clock through a synchroniser and emits a one-cycle enable strobe on each slow rising edge. It also measures period and high time in fast-clock cycles and declares lock when the measured ratio matches DIVIDE_BY. It sits in the user domain beside the clock divider and lets fast logic qualify, and use as enables, a clock it did not generate.

## Interface
- DIVIDE_BY, 4: expected slow-clock period in fast-clock cycles; must be ≥ 2.
- TOLERANCE, 0: allowed ± deviation of a measured period from DIVIDE_BY.
- LOCK_COUNT, 4: consecutive good periods required to assert lock; must be ≥ 1.
- CNT_W, 8: counter/measurement width; 2^CNT_W − 1 must exceed DIVIDE_BY + TOLERANCE.
- clk_200M_i  input  1  fast clock; sole clock of the block.
- rst_i  input  1  reset; synchronous, active-high.
- clk_div_i  input  1  slow clock under observation; asynchronous to clk_200M_i for sampling purposes.
- enable_i  input  1  monitor enable; low forces IDLE.
- clear_i  input  1  one-cycle clear of sticky fault_o.
- edge_stb_o  output  1  one-cycle pulse per synchronised rising edge of clk_div_i.
- period_o  output  CNT_W  last complete measured period.
- high_o  output  CNT_W  last complete measured high time.
- locked_o  output  1  ratio is verified.
- fault_o  output  1  sticky: a lost lock or timeout has occurred.

## Operation
- Sync chain: s1 ← clk_div_i, s2 ← s1, s3 ← s2. rise = s2 & ~s3, fall = ~s2 & s3.
- Period counter pc, saturating at all-ones:
  - on rise, capture pc into period_o and set pc ← 1;
  - otherwise pc ← pc + 1 unless saturated.
- High counter hc:
  - on rise, hc ← 1;
  - while s2 is high, increment with saturation;
  - on fall, capture hc into high_o.
- good = (period_o candidate ≥ DIVIDE_BY − TOLERANCE) and (≤ DIVIDE_BY + TOLERANCE), with no underflow of the lower bound; compared on the captured value.
- States:
  - IDLE: entered whenever enable_i is low. pc, hc and good_cnt are 0. locked_o = 0. edge_stb_o = 0.
  - ARM: enable_i high and waiting for the first rise. That rise only restarts pc/hc; period_o and high_o are not updated. Next state is TRACK.
  - TRACK: on rise, capture period_o.
    - If good: good_cnt++.
    - If not good: good_cnt ← 0.
    - When good_cnt reaches LOCK_COUNT, go to LOCKED.
  - LOCKED: locked_o = 1. A rise with a bad period sets fault_o and moves to TRACK with good_cnt = 0.
- Timeout: pc saturating in TRACK or LOCKED moves to ARM. From LOCKED this also sets fault_o.
- fault_o is cleared only by clear_i or rst_i. A fault set and clear_i in the same cycle leave fault_o = 1.
- period_o and high_o hold their values through IDLE and ARM.

## Timing
- Reset values: edge_stb_o 0, period_o 0, high_o 0, locked_o 0, fault_o 0. State IDLE, sync flops 0.
- Rise latency: clk_div_i sampled high at fast edge N gives edge_stb_o high during cycle N+3, for exactly one cycle.
- period_o updates on the same edge edge_stb_o asserts.
- high_o updates 3 cycles after clk_div_i is first sampled low.
- locked_o rises in the cycle after the edge_stb_o that completes the LOCK_COUNT-th good period.
- locked_o falls in the cycle after:
  - a bad-period strobe;
  - pc saturation;
  - enable_i being sampled low.
- fault_o sets in the same cycle locked_o falls, for the bad-period and timeout cases only.
- Reset mid-operation returns the block to reset values on the next edge. No partial measurement survives reset.
- enable_i dropping mid-period discards the partial count. On re-enable, ARM requires a fresh rise.

## Test plan
- Ideal divide-by-4 input (2 high / 2 low), defaults:
  - edge_stb_o every 4 cycles;
  - period_o = 4 and high_o = 2 after the second edge;
  - locked_o = 1 after the 5th edge strobe;
  - fault_o stays 0.
- After lock, stretch one period to 6 cycles: locked_o → 0, fault_o → 1, period_o = 6. Four more 4-cycle periods re-lock; fault_o stays 1 until clear_i, then reads 0.
- TOLERANCE = 1 with periods alternating 3 and 5: locked_o asserts. The same stimulus with TOLERANCE = 0 never locks and leaves fault_o = 0.
- After lock, stop clk_div_i (held low): after 255 idle cycles (CNT_W = 8) the state goes to ARM, locked_o = 0, fault_o = 1, and edge_stb_o stays silent.
- Assert clear_i in the same cycle as a fault event: fault_o = 1.
- Assert rst_i mid-TRACK: all outputs read 0 next cycle. Lock then requires ARM plus LOCK_COUNT good periods again.
